fc_dma_scheduler: RTL
=====================

Name: fc_dma_scheduler

Overview:
Sequences and shares the fully-connected layer's single DMA engine between NUM_REQ requesters (input-vector loader, weight-row loader, ...). Grants requesters round-robin and splits each transfer into chunks of at most BUFFER_SIZE words. Issues one DMA read per chunk, then holds the filled DMA buffer for the granted requester until that requester acknowledges it. Sits between the FC layer control and the DMA; it does not move data itself.

Parameters:
NUM_REQ, 2, number of requesters (>=1)
BUFFER_SIZE, 120, DMA buffer depth in words; maximum chunk length
MEM_ADDRESS_WIDTH, 10, memory address and count width

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
i_req  input  NUM_REQ  per-requester request level; held until o_done for that requester
i_req_address  input  NUM_REQ*MEM_ADDRESS_WIDTH  start addresses, requester k at slice k
i_req_count  input  NUM_REQ*MEM_ADDRESS_WIDTH  total words, requester k at slice k
o_grant  output  NUM_REQ  one-hot owner of the DMA; zero when idle
o_chunk_valid  output  1  DMA buffer holds a complete chunk for the granted requester
o_chunk_len  output  MEM_ADDRESS_WIDTH  valid words in the current chunk
o_chunk_last  output  1  current chunk is the final one of the request
i_chunk_ack  input  1  granted requester has consumed the buffer
o_done  output  1  one-cycle pulse when the granted request completes
o_dma_read  output  1  one-cycle read strobe to the DMA
o_dma_address  output  MEM_ADDRESS_WIDTH  chunk start address
o_dma_count  output  MEM_ADDRESS_WIDTH  chunk length
i_dma_ready  input  1  DMA completion pulse

Behaviour:
- Reset, synchronous and active-high: state IDLE, round-robin pointer 0, remaining 0. All outputs 0.
- FSM states: IDLE, ISSUE, WAIT, HOLD, DONE.
- IDLE:
  - If any i_req bit is set, pick the first set bit at or after the pointer, searching upward with wrap.
  - Latch that requester's address into cur_addr and its count into remaining; set o_grant.
  - If the latched count is 0, go to DONE. Otherwise go to ISSUE.
- ISSUE (exactly one cycle):
  - o_dma_read=1.
  - o_dma_address=cur_addr.
  - o_dma_count=o_chunk_len=min(remaining, BUFFER_SIZE).
  - o_chunk_last=(remaining<=BUFFER_SIZE).
  - Next state WAIT.
- WAIT:
  - o_dma_address, o_dma_count, o_chunk_len and o_chunk_last hold their values.
  - On i_dma_ready=1, go to HOLD.
  - i_dma_ready is ignored in every other state; stray pulses after reset have no effect.
- HOLD:
  - o_chunk_valid=1 until i_chunk_ack=1 is sampled. i_chunk_ack may arrive in the same cycle valid first rises.
  - On ack: cur_addr += chunk_len and remaining -= chunk_len.
  - If the chunk was last, go to DONE; else go to ISSUE.
  - Ack while not in HOLD is ignored.
- DONE (one cycle):
  - o_done=1 and o_grant still asserted.
  - Pointer becomes granted index + 1, mod NUM_REQ. Next state IDLE.
  - o_grant drops on entry to IDLE; a new arbitration may occur the following cycle.
- Latency: i_req seen in IDLE at edge n gives o_dma_read high in cycle n+1. Back-to-back chunks leave one ISSUE cycle after the ack.
- Arithmetic:
  - Address addition wraps modulo 2^MEM_ADDRESS_WIDTH, with no error.
  - chunk_len is never 0 in ISSUE.
- Request and grant rules:
  - Request inputs are sampled only in IDLE; changes during a grant are ignored.
  - Deasserting i_req mid-transfer does not abort; the request completes normally.
  - A requester whose i_req is still high after its o_done is re-eligible, after the others in round-robin order.
- Reset mid-operation returns to IDLE immediately. An in-flight DMA completion arriving afterwards is discarded.

Test Plan:
- Reset, then req0 with addr=10, count=50 (BUFFER_SIZE=120) -> one o_dma_read with address 10, count 50; o_chunk_valid with len 50 and last=1; ack -> o_done one cycle; grant returns to 0.
- req1 with addr=100, count=300 -> three DMA reads: (100,120), (220,120), (340,60). o_chunk_last set only on the third chunk; o_done after the third ack.
- req0 and req1 both high from reset, count=5 each -> grants in order 0, 1, 0, 1 while held; no two o_grant bits ever set together.
- req0 with count=0 -> grant, then o_done in the next cycle; o_dma_read never asserted.
- Ack delayed 20 cycles in HOLD -> o_chunk_valid held high throughout with no new o_dma_read. Stray i_dma_ready pulses in HOLD and IDLE are ignored.
- rst asserted in WAIT, then i_dma_ready pulsed -> all outputs 0 and state IDLE; no o_chunk_valid appears.

Source files
------------

// File: rtl/fc_dma_scheduler_if.sv
// Requester / DMA handshake bundle for the FC-layer DMA scheduler.
// The scheduler connects through the slave modport. The FC control and DMA
// side, or a testbench standing in for them, connects through the master modport.
interface fc_dma_scheduler_if #(
    parameter int NUM_REQ           = 2,
    parameter int MEM_ADDRESS_WIDTH = 10
);
    logic [NUM_REQ-1:0]                   i_req;
    logic [NUM_REQ*MEM_ADDRESS_WIDTH-1:0] i_req_address;
    logic [NUM_REQ*MEM_ADDRESS_WIDTH-1:0] i_req_count;
    logic [NUM_REQ-1:0]                   o_grant;
    logic                                 o_chunk_valid;
    logic [MEM_ADDRESS_WIDTH-1:0]         o_chunk_len;
    logic                                 o_chunk_last;
    logic                                 i_chunk_ack;
    logic                                 o_done;
    logic                                 o_dma_read;
    logic [MEM_ADDRESS_WIDTH-1:0]         o_dma_address;
    logic [MEM_ADDRESS_WIDTH-1:0]         o_dma_count;
    logic                                 i_dma_ready;

    modport slave (
        input  i_req, i_req_address, i_req_count, i_chunk_ack, i_dma_ready,
        output o_grant, o_chunk_valid, o_chunk_len, o_chunk_last, o_done,
               o_dma_read, o_dma_address, o_dma_count
    );

    modport master (
        output i_req, i_req_address, i_req_count, i_chunk_ack, i_dma_ready,
        input  o_grant, o_chunk_valid, o_chunk_len, o_chunk_last, o_done,
               o_dma_read, o_dma_address, o_dma_count
    );
endinterface

// File: rtl/fc_dma_scheduler.sv
// Round-robin owner of the FC layer's single DMA engine. Splits each granted
// transfer into chunks of at most BUFFER_SIZE words, issues one DMA read per
// chunk and holds the filled buffer for the requester until it acknowledges.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no owner; arbitrate among raised requests
// S_ISSUE | one-cycle DMA read strobe for the current chunk
// S_WAIT  | chunk read in flight; wait for the DMA completion pulse
// S_HOLD  | buffer full; o_chunk_valid until the requester acks
// S_DONE  | one-cycle o_done; advance round-robin pointer past the owner
module fc_dma_scheduler #(
    parameter int NUM_REQ           = 2,
    parameter int BUFFER_SIZE       = 120,
    parameter int MEM_ADDRESS_WIDTH = 10
) (
    input  logic                clk,
    input  logic                rst,
    fc_dma_scheduler_if.slave   bus
);

    localparam int AW = MEM_ADDRESS_WIDTH;
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [AW-1:0] BUF_WORDS = AW'(BUFFER_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      w_ptr_nxt;
    logic [IW-1:0]      r_gidx;
    logic [IW-1:0]      w_gidx_nxt;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] w_grant_nxt;
    logic [AW-1:0]      r_cur_addr;
    logic [AW-1:0]      w_cur_addr_nxt;
    logic [AW-1:0]      r_remaining;
    logic [AW-1:0]      w_remaining_nxt;

    logic               w_found_hi;
    logic               w_found_lo;
    logic [IW-1:0]      w_idx_hi;
    logic [IW-1:0]      w_idx_lo;
    logic               w_any_req;
    logic [IW-1:0]      w_sel_idx;
    logic [AW-1:0]      w_sel_addr;
    logic [AW-1:0]      w_sel_count;

    logic [AW-1:0]      w_chunk_len;
    logic               w_chunk_last;
    logic               w_in_chunk;

    // Round-robin pick: lowest raised index at or above the pointer wins,
    // otherwise the lowest raised index below it (wrap-around).
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_idx_hi   = '0;
        w_idx_lo   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.i_req[k]) begin
                if (k >= int'(r_ptr)) begin
                    w_found_hi = 1'b1;
                    w_idx_hi   = IW'(k);
                end else begin
                    w_found_lo = 1'b1;
                    w_idx_lo   = IW'(k);
                end
            end
        end
        w_any_req = w_found_hi | w_found_lo;
        w_sel_idx = w_found_hi ? w_idx_hi : w_idx_lo;
    end

    // Fetch the winning requester's address and count slices.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_count = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IW'(k) == w_sel_idx) begin
                w_sel_addr  = bus.i_req_address[k*AW +: AW];
                w_sel_count = bus.i_req_count[k*AW +: AW];
            end
        end
    end

    // Current chunk geometry; remaining only moves on ack, so it stays stable
    // from ISSUE through HOLD.
    always_comb begin
        w_chunk_last = (r_remaining <= BUF_WORDS);
        w_chunk_len  = w_chunk_last ? r_remaining : BUF_WORDS;
        w_in_chunk   = (r_state == S_ISSUE) || (r_state == S_WAIT) ||
                       (r_state == S_HOLD);
    end

    // Next-state and next-register logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_gidx_nxt      = r_gidx;
        w_grant_nxt     = r_grant;
        w_cur_addr_nxt  = r_cur_addr;
        w_remaining_nxt = r_remaining;
        unique case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_gidx_nxt      = w_sel_idx;
                    w_grant_nxt     = NUM_REQ'(1) << w_sel_idx;
                    w_cur_addr_nxt  = w_sel_addr;
                    w_remaining_nxt = w_sel_count;
                    w_state_nxt     = (w_sel_count == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.i_dma_ready) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.i_chunk_ack) begin
                    w_cur_addr_nxt  = r_cur_addr + w_chunk_len;
                    w_remaining_nxt = r_remaining - w_chunk_len;
                    w_state_nxt     = w_chunk_last ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                w_ptr_nxt   = (r_gidx == IW'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;
                w_grant_nxt = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_gidx      <= '0;
            r_grant     <= '0;
            r_cur_addr  <= '0;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_gidx      <= w_gidx_nxt;
            r_grant     <= w_grant_nxt;
            r_cur_addr  <= w_cur_addr_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

    assign bus.o_grant       = r_grant;
    assign bus.o_dma_read    = (r_state == S_ISSUE);
    assign bus.o_chunk_valid = (r_state == S_HOLD);
    assign bus.o_done        = (r_state == S_DONE);
    assign bus.o_dma_address = w_in_chunk ? r_cur_addr  : '0;
    assign bus.o_dma_count   = w_in_chunk ? w_chunk_len : '0;
    assign bus.o_chunk_len   = w_in_chunk ? w_chunk_len : '0;
    assign bus.o_chunk_last  = w_in_chunk & w_chunk_last;

endmodule
